// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: frame-level glue between the SPI byte shifter and the stepgen/IO datapath.
// Readback is snapshotted at frame start; received bytes land in shadows and commit only on full frames.
module spi_frame_ctrl #(
    parameter int PW        = 21,
    parameter int VW        = 12,
    parameter int O         = 9,
    parameter int I         = 13,
    parameter int T         = 4,
    parameter int FRAME_LEN = 20,
    parameter int WDT_BIT   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ssel_start,
    input  logic            ssel_end,
    input  logic            byte_rx,
    input  logic [7:0]      rx_data,
    input  logic [4*PW-1:0] pos_in,
    input  logic [I-1:0]    din,
    input  logic [15:0]     rpm,
    output logic [7:0]      tx_data,
    output logic [4*VW-1:0] vel,
    output logic [O-1:0]    dout,
    output logic [T-1:0]    dirtime,
    output logic [T-1:0]    steptime,
    output logic [1:0]      tap,
    output logic            spol,
    output logic [7:0]      pwm,
    output logic            commit,
    output logic            wdt_kick,
    output logic            frame_err,
    output logic [7:0]      err_cnt
);

    localparam int         NSHADOW     = 13;
    localparam logic [4:0] CNT_MAX     = 5'd31;
    localparam logic [4:0] FRAME_LEN_C = 5'(FRAME_LEN);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_COMMIT} state_t;

    state_t          state_q;
    logic [4:0]      byte_cnt_q;
    logic [4:0]      byte_cnt_d;
    logic [4:0]      cnt_inc;
    logic [PW-1:0]   pos_snap_q [4];
    logic [I-1:0]    din_snap_q;
    logic [15:0]     rpm_snap_q;
    logic [7:0]      shadow_q [NSHADOW];
    logic            shadow_we;
    logic            frame_full;
    logic [7:0]      err_cnt_q;
    logic [7:0]      err_cnt_inc;

    logic [4*VW-1:0] vel_q;
    logic [4*VW-1:0] vel_dec;
    logic [O-1:0]    dout_q;
    logic [T-1:0]    dirtime_q;
    logic [T-1:0]    steptime_q;
    logic [1:0]      tap_q;
    logic            spol_q;
    logic [7:0]      pwm_q;
    logic            commit_q;
    logic            wdt_kick_q;
    logic            frame_err_q;

    logic [7:0]      tx_data_d;
    logic [PW-1:0]   tx_pos;

    // Count as it will stand after this cycle, so a byte coinciding with ssel_end still counts.
    assign cnt_inc     = (byte_cnt_q == CNT_MAX) ? CNT_MAX : byte_cnt_q + 5'd1;
    assign byte_cnt_d  = byte_rx ? cnt_inc : byte_cnt_q;
    assign frame_full  = (byte_cnt_d >= FRAME_LEN_C);
    assign shadow_we   = (state_q == S_RECV) && byte_rx && !ssel_start;
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSHADOW; k++) shadow_q[k] <= '0;
        end else if (shadow_we) begin
            for (int k = 0; k < NSHADOW; k++) begin
                if (byte_cnt_q == 5'(k)) shadow_q[k] <= rx_data;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_vel
        assign vel_dec[gi*VW +: VW] = {shadow_q[2*gi+1][VW-9:0], shadow_q[2*gi]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            for (int k = 0; k < 4; k++) pos_snap_q[k] <= '0;
            din_snap_q  <= '0;
            rpm_snap_q  <= '0;
            err_cnt_q   <= '0;
            vel_q       <= '0;
            dout_q      <= '0;
            dirtime_q   <= '0;
            steptime_q  <= '0;
            tap_q       <= '0;
            spol_q      <= 1'b0;
            pwm_q       <= '0;
            commit_q    <= 1'b0;
            wdt_kick_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            commit_q    <= 1'b0;
            wdt_kick_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ssel_start) begin
                        state_q    <= S_RECV;
                        byte_cnt_q <= '0;
                        for (int k = 0; k < 4; k++) pos_snap_q[k] <= pos_in[k*PW +: PW];
                        din_snap_q <= din;
                        rpm_snap_q <= rpm;
                    end
                end
                S_RECV: begin
                    if (ssel_start) begin
                        // Missed end of the previous frame: drop it and start over.
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= err_cnt_inc;
                        byte_cnt_q  <= '0;
                        for (int k = 0; k < 4; k++) pos_snap_q[k] <= pos_in[k*PW +: PW];
                        din_snap_q  <= din;
                        rpm_snap_q  <= rpm;
                    end else begin
                        byte_cnt_q <= byte_cnt_d;
                        if (ssel_end) begin
                            if (frame_full) begin
                                state_q    <= S_COMMIT;
                                commit_q   <= 1'b1;
                                wdt_kick_q <= shadow_q[9][WDT_BIT];
                            end else begin
                                state_q     <= S_IDLE;
                                frame_err_q <= 1'b1;
                                err_cnt_q   <= err_cnt_inc;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    state_q    <= S_IDLE;
                    vel_q      <= vel_dec;
                    dout_q     <= {shadow_q[9][O-9:0], shadow_q[8]};
                    spol_q     <= shadow_q[10][7];
                    dirtime_q  <= shadow_q[10][T-1:0];
                    tap_q      <= shadow_q[11][7:6];
                    steptime_q <= shadow_q[11][T-1:0];
                    pwm_q      <= shadow_q[12];
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_pos = pos_snap_q[byte_cnt_q[3:2]];

    always_comb begin
        tx_data_d = '0;
        if (state_q != S_IDLE) begin
            if (byte_cnt_q >= 5'd20) begin
                tx_data_d = {3'b000, byte_cnt_q};
            end else if (byte_cnt_q >= 5'd16) begin
                case (byte_cnt_q[1:0])
                    2'd0:    tx_data_d = din_snap_q[7:0];
                    2'd1:    tx_data_d = 8'(din_snap_q[I-1:8]);
                    2'd2:    tx_data_d = rpm_snap_q[7:0];
                    default: tx_data_d = rpm_snap_q[15:8];
                endcase
            end else begin
                case (byte_cnt_q[1:0])
                    2'd0:    tx_data_d = tx_pos[7:0];
                    2'd1:    tx_data_d = tx_pos[15:8];
                    2'd2:    tx_data_d = 8'(tx_pos[PW-1:16]);
                    default: tx_data_d = 8'd0;
                endcase
            end
        end
    end

    assign tx_data   = tx_data_d;
    assign vel       = vel_q;
    assign dout      = dout_q;
    assign dirtime   = dirtime_q;
    assign steptime  = steptime_q;
    assign tap       = tap_q;
    assign spol      = spol_q;
    assign pwm       = pwm_q;
    assign commit    = commit_q;
    assign wdt_kick  = wdt_kick_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
